// File: rtl/fifo_nibble_tx.sv
// Drains the nibble FIFO one entry per frame and serialises it onto tx_out as
// start bit, data LSB-first, optional even parity bit, stop bit.
module fifo_nibble_tx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_rd_rq,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    state_t              state_r, state_next_s;
    logic [CNT_W-1:0]    cnt_r, cnt_next_s;
    logic [BIT_W-1:0]    bit_r, bit_next_s;
    logic [DATA_W-1:0]   shift_r, shift_next_s;
    logic                par_r, par_next_s;
    logic                tx_out_r, tx_out_next_s;
    logic                fifo_rd_rq_r, busy_r, frame_done_r;
    logic                cnt_wrap_s;

    assign cnt_wrap_s = (cnt_r == CNT_LAST);

    // Next-state, bit timing and shift register update
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        bit_next_s   = bit_r;
        shift_next_s = shift_r;
        par_next_s   = par_r;
        case (state_r)
            IDLE: begin
                if (tx_en && !fifo_empty) begin
                    state_next_s = REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                state_next_s = LOAD;
            end
            LOAD: begin
                shift_next_s = fifo_rdata;
                par_next_s   = even_parity(fifo_rdata);
                cnt_next_s   = CNT_ZERO;
                bit_next_s   = BIT_ZERO;
                state_next_s = START;
            end
            START, PARITY, STOP: begin
                if (cnt_wrap_s) begin
                    cnt_next_s = CNT_ZERO;
                    if (state_r == START) begin
                        state_next_s = DATA;
                    end else if (state_r == PARITY) begin
                        state_next_s = STOP;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_wrap_s) begin
                    cnt_next_s   = CNT_ZERO;
                    shift_next_s = {1'b0, shift_r[DATA_W-1:1]};
                    if (bit_r == BIT_LAST) begin
                        bit_next_s   = BIT_ZERO;
                        state_next_s = (PARITY_EN != 32'sd0) ? PARITY : STOP;
                    end else begin
                        bit_next_s = bit_r + BIT_ONE;
                    end
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = CNT_ZERO;
                bit_next_s   = BIT_ZERO;
            end
        endcase
    end

    // Line level for the cycle after the edge, so tx_out can be registered
    always_comb begin
        tx_out_next_s = 1'b1;
        case (state_next_s)
            START:   tx_out_next_s = 1'b0;
            DATA:    tx_out_next_s = shift_next_s[0];
            PARITY:  tx_out_next_s = par_next_s;
            default: tx_out_next_s = 1'b1;
        endcase
    end

    // State and registered outputs; outputs are decoded from next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= CNT_ZERO;
            bit_r        <= BIT_ZERO;
            shift_r      <= {DATA_W{1'b0}};
            par_r        <= 1'b0;
            tx_out_r     <= 1'b1;
            fifo_rd_rq_r <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            cnt_r        <= cnt_next_s;
            bit_r        <= bit_next_s;
            shift_r      <= shift_next_s;
            par_r        <= par_next_s;
            tx_out_r     <= tx_out_next_s;
            fifo_rd_rq_r <= (state_next_s == REQ);
            busy_r       <= (state_next_s != IDLE);
            frame_done_r <= (state_next_s == STOP) && (cnt_next_s == CNT_LAST);
        end
    end

    assign fifo_rd_rq = fifo_rd_rq_r;
    assign tx_out     = tx_out_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

endmodule
